fpu_mul_param: RTL

//  Parametrised multi-cycle IEEE-754 multiplier; next generation of the FPU multiply unit.

---
 rtl/fpu_mul_param.sv | 288 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/fpu_mul_param.sv
// ============================================================================
// Module  : fpu_mul_param
// Brief   : Multi-cycle parametrised IEEE-754 multiplier with runtime rounding
//           mode, exception flags and denormal support.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fpu_mul_param #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [EXP_W+MAN_W:0]   din1,
    input  logic [EXP_W+MAN_W:0]   din2,
    input  logic                   valid,
    input  logic [1:0]             rnd_mode,
    output logic                   busy,
    output logic [EXP_W+MAN_W:0]   result,
    output logic [3:0]             flags,
    output logic                   ready
);

    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int EW    = EXP_W + 2;
    localparam int MW    = MAN_W + 1;
    localparam int PW    = 2 * MW;
    localparam int CAP   = MAN_W + 3;
    localparam int CW    = $clog2(CAP + 1);
    localparam int c_BIAS = 2 ** (EXP_W - 1) - 1;

    localparam logic signed [EW-1:0] c_BIAS_E = EW'(c_BIAS);
    localparam logic signed [EW-1:0] c_EMIN   = EW'(1 - c_BIAS);
    localparam logic signed [EW-1:0] c_E1     = EW'(1);
    localparam logic [EXP_W-1:0]     c_BIAS_F = EXP_W'(c_BIAS);
    localparam logic [CW-1:0]        c_CAP    = CW'(CAP);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_UNPACK  = 4'd1;
    localparam logic [3:0] S_SPECIAL = 4'd2;
    localparam logic [3:0] S_NORM_A  = 4'd3;
    localparam logic [3:0] S_NORM_B  = 4'd4;
    localparam logic [3:0] S_MULT    = 4'd5;
    localparam logic [3:0] S_ALIGN   = 4'd6;
    localparam logic [3:0] S_DENORM  = 4'd7;
    localparam logic [3:0] S_ROUND   = 4'd8;
    localparam logic [3:0] S_PACK    = 4'd9;
    localparam logic [3:0] S_DONE    = 4'd10;

    localparam logic [W-1:0] c_QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    logic [3:0]              r_state, w_state_nxt;
    logic [W-1:0]            r_a, r_b;
    logic [1:0]              r_rm;
    logic                    r_sa, r_sb, r_sign;
    logic signed [EW-1:0]    r_ea, r_eb, r_exp;
    logic [MW-1:0]           r_ma, r_mb, r_m;
    logic [PW-1:0]           r_prod;
    logic                    r_g, r_r, r_s, r_tiny;
    logic [CW-1:0]           r_cnt;
    logic [W-1:0]            r_z;
    logic [3:0]              r_f;

    logic [EXP_W-1:0]        w_a_exp, w_b_exp;
    logic [MAN_W-1:0]        w_a_man, w_b_man;
    logic                    w_nan_a, w_nan_b, w_snan_a, w_snan_b;
    logic                    w_inf_a, w_inf_b, w_zero_a, w_zero_b;
    logic                    w_special;
    logic [W-1:0]            w_sp_z;
    logic [3:0]              w_sp_f;
    logic                    w_below, w_inc, w_ovf, w_inx;
    logic [MW:0]             w_m_inc;
    logic [EXP_W-1:0]        w_efield;
    logic [W-1:0]            w_pk_z;
    logic [3:0]              w_pk_f;

    assign w_a_exp  = r_a[W-2 -: EXP_W];
    assign w_b_exp  = r_b[W-2 -: EXP_W];
    assign w_a_man  = r_a[MAN_W-1:0];
    assign w_b_man  = r_b[MAN_W-1:0];
    assign w_nan_a  = (&w_a_exp) & (|w_a_man);
    assign w_nan_b  = (&w_b_exp) & (|w_b_man);
    assign w_snan_a = w_nan_a & ~w_a_man[MAN_W-1];
    assign w_snan_b = w_nan_b & ~w_b_man[MAN_W-1];
    assign w_inf_a  = (&w_a_exp) & ~(|w_a_man);
    assign w_inf_b  = (&w_b_exp) & ~(|w_b_man);
    assign w_zero_a = ~(|w_a_exp) & ~(|w_a_man);
    assign w_zero_b = ~(|w_b_exp) & ~(|w_b_man);
    assign w_special = w_nan_a | w_nan_b | w_inf_a | w_inf_b | w_zero_a | w_zero_b;

    // NaN outranks Inf*0, which outranks plain Inf, which outranks zero.
    always_comb begin
        w_sp_z = '0;
        w_sp_f = 4'b0000;
        if (w_nan_a | w_nan_b) begin
            w_sp_z = c_QNAN;
            w_sp_f = {w_snan_a | w_snan_b, 3'b000};
        end else if ((w_inf_a & w_zero_b) | (w_zero_a & w_inf_b)) begin
            w_sp_z = c_QNAN;
            w_sp_f = 4'b1000;
        end else if (w_inf_a | w_inf_b) begin
            w_sp_z = {r_a[W-1] ^ r_b[W-1], {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (w_zero_a | w_zero_b) begin
            w_sp_z = {r_a[W-1] ^ r_b[W-1], {(W-1){1'b0}}};
        end
    end

    assign w_below = (r_exp < c_EMIN);
    assign w_m_inc = {1'b0, r_m} + {{MW{1'b0}}, 1'b1};

    always_comb begin
        w_inc = 1'b0;
        case (r_rm)
            2'd0:    w_inc = r_g & (r_r | r_s | r_m[0]);
            2'd1:    w_inc = 1'b0;
            2'd2:    w_inc = (r_g | r_r | r_s) & ~r_sign;
            default: w_inc = (r_g | r_r | r_s) & r_sign;
        endcase
    end

    assign w_ovf    = (r_exp > c_BIAS_E);
    assign w_inx    = r_g | r_r | r_s | w_ovf;
    assign w_efield = r_exp[EXP_W-1:0] + c_BIAS_F;

    always_comb begin
        w_pk_z = '0;
        if (w_ovf) begin
            case (r_rm)
                2'd0:    w_pk_z = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                2'd1:    w_pk_z = {r_sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
                2'd2:    w_pk_z = r_sign ? {1'b1, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}}
                                         : {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                default: w_pk_z = r_sign ? {1'b1, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                                         : {1'b0, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
            endcase
        end else if (!r_m[MAN_W]) begin
            w_pk_z = {r_sign, {EXP_W{1'b0}}, r_m[MAN_W-1:0]};
        end else begin
            w_pk_z = {r_sign, w_efield, r_m[MAN_W-1:0]};
        end
        w_pk_f = {1'b0, w_ovf, r_tiny & w_inx, w_inx};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (valid) w_state_nxt = S_UNPACK;
            S_UNPACK:  w_state_nxt = S_SPECIAL;
            S_SPECIAL: w_state_nxt = w_special ? S_DONE : S_NORM_A;
            S_NORM_A:  if (r_ma[MAN_W]) w_state_nxt = S_NORM_B;
            S_NORM_B:  if (r_mb[MAN_W]) w_state_nxt = S_MULT;
            S_MULT:    w_state_nxt = S_ALIGN;
            S_ALIGN:   w_state_nxt = S_DENORM;
            S_DENORM:  if (!(w_below && (r_cnt < c_CAP))) w_state_nxt = S_ROUND;
            S_ROUND:   w_state_nxt = S_PACK;
            S_PACK:    w_state_nxt = S_DONE;
            S_DONE:    w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a <= '0; r_b <= '0; r_rm <= 2'd0;
            r_sa <= 1'b0; r_sb <= 1'b0; r_sign <= 1'b0;
            r_ea <= '0; r_eb <= '0; r_exp <= '0;
            r_ma <= '0; r_mb <= '0; r_m <= '0; r_prod <= '0;
            r_g <= 1'b0; r_r <= 1'b0; r_s <= 1'b0; r_tiny <= 1'b0;
            r_cnt <= '0; r_z <= '0; r_f <= 4'b0000;
            result <= '0; flags <= 4'b0000; ready <= 1'b0;
        end else begin
            ready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (valid) begin
                        r_a  <= din1;
                        r_b  <= din2;
                        r_rm <= rnd_mode;
                    end
                end
                S_UNPACK: begin
                    r_sa <= r_a[W-1];
                    r_sb <= r_b[W-1];
                    r_ea <= (w_a_exp == '0) ? c_EMIN : ($signed({2'b00, w_a_exp}) - c_BIAS_E);
                    r_eb <= (w_b_exp == '0) ? c_EMIN : ($signed({2'b00, w_b_exp}) - c_BIAS_E);
                    r_ma <= {|w_a_exp, w_a_man};
                    r_mb <= {|w_b_exp, w_b_man};
                end
                S_SPECIAL: begin
                    if (w_special) begin
                        r_z <= w_sp_z;
                        r_f <= w_sp_f;
                    end
                end
                S_NORM_A: begin
                    if (!r_ma[MAN_W]) begin
                        r_ma <= r_ma << 1;
                        r_ea <= r_ea - c_E1;
                    end
                end
                S_NORM_B: begin
                    if (!r_mb[MAN_W]) begin
                        r_mb <= r_mb << 1;
                        r_eb <= r_eb - c_E1;
                    end
                end
                S_MULT: begin
                    r_sign <= r_sa ^ r_sb;
                    r_exp  <= r_ea + r_eb;
                    r_prod <= {{MW{1'b0}}, r_ma} * {{MW{1'b0}}, r_mb};
                end
                S_ALIGN: begin
                    r_cnt  <= '0;
                    r_tiny <= 1'b0;
                    if (r_prod[PW-1]) begin
                        r_exp <= r_exp + c_E1;
                        r_m   <= r_prod[PW-1 -: MW];
                        r_g   <= r_prod[PW-1-MW];
                        r_r   <= r_prod[PW-2-MW];
                        r_s   <= |r_prod[PW-3-MW:0];
                    end else begin
                        r_m   <= r_prod[PW-2 -: MW];
                        r_g   <= r_prod[PW-2-MW];
                        r_r   <= r_prod[PW-3-MW];
                        r_s   <= |r_prod[PW-4-MW:0];
                    end
                end
                S_DENORM: begin
                    if (w_below) begin
                        r_tiny <= 1'b1;
                        if (r_cnt < c_CAP) begin
                            r_m   <= r_m >> 1;
                            r_g   <= r_m[0];
                            r_r   <= r_g;
                            r_s   <= r_s | r_r;
                            r_exp <= r_exp + c_E1;
                            r_cnt <= r_cnt + 1'b1;
                        end else begin
                            // Shift budget exhausted: everything left is below the LSB.
                            r_s   <= r_s | r_r | r_g | (|r_m);
                            r_m   <= '0;
                            r_g   <= 1'b0;
                            r_r   <= 1'b0;
                            r_exp <= c_EMIN;
                        end
                    end
                end
                S_ROUND: begin
                    if (w_inc) begin
                        if (w_m_inc[MW]) begin
                            r_m   <= w_m_inc[MW:1];
                            r_exp <= r_exp + c_E1;
                        end else begin
                            r_m   <= w_m_inc[MW-1:0];
                        end
                    end
                end
                S_PACK: begin
                    r_z <= w_pk_z;
                    r_f <= w_pk_f;
                end
                S_DONE: begin
                    result <= r_z;
                    flags  <= r_f;
                    ready  <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire
